fetch_unit: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register. It holds the PC and a single-line (16-byte) instruction buffer, and it runs a miss FSM against the instruction-memory port. It produces the instruction, PC, ROB index, fetch exception vector and I-cache stall that IF/ID latches each cycle, and it accepts branch and exception redirects from later stages.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one 16-byte line buffer and a line-fill FSM
// feeding the IF/ID register; accepts branch and trap redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] MEM_LIMIT = 32'h0001_0000,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_IFID_write_disable,
  input  logic         in_d_cache_stall,
  input  logic         in_branch_taken,
  input  logic [31:0]  in_branch_target,
  input  logic         in_exception_redirect,
  input  logic [31:0]  in_exception_target,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic [127:0] mem_data,
  output logic [31:0]  out_instruction,
  output logic [31:0]  out_PC,
  output logic [3:0]   out_complete_idx,
  output logic [2:0]   out_exception_vector,
  output logic         out_i_cache_stall
);

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t         r_state, w_state_nxt;
  logic [31:0]    r_pc, w_pc_nxt;
  logic [31:0]    r_miss_addr;
  logic           r_buf_valid;
  logic [27:0]    r_tag;
  logic [127:0]   r_line;
  logic [3:0]     r_idx;

  logic           w_hit, w_fault, w_stall, w_fill, w_start_miss;
  logic           w_hold, w_redirect, w_deliver;
  logic [2:0]     w_vec;
  logic [31:0]    w_insn, w_word;

  assign w_vec      = {1'b0, r_pc >= MEM_LIMIT, r_pc[1:0] != 2'b00};
  assign w_fault    = |w_vec;
  assign w_hit      = r_buf_valid && (r_tag == r_pc[31:4]);
  assign w_word     = r_line[{r_pc[3:2], 5'd0} +: 32];
  assign w_redirect = in_exception_redirect | in_branch_taken;
  assign w_hold     = in_IFID_write_disable | in_d_cache_stall;

  always_comb begin
    w_state_nxt  = r_state;
    w_stall      = 1'b1;
    w_insn       = '0;
    w_fill       = 1'b0;
    w_start_miss = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fault) begin
          w_stall = 1'b0;
          w_insn  = NOP_INSN;
        end else if (w_hit) begin
          w_stall = 1'b0;
          w_insn  = w_word;
        end else begin
          w_start_miss = 1'b1;
          w_state_nxt  = S_MISS;
        end
      end
      S_MISS: begin
        if (mem_ready) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Redirects move the PC even mid-fill; the fill still lands on r_miss_addr.
  always_comb begin
    w_pc_nxt = r_pc;
    if (in_exception_redirect)
      w_pc_nxt = in_exception_target;
    else if (in_branch_taken)
      w_pc_nxt = in_branch_target;
    else if (!w_hold && !w_stall)
      w_pc_nxt = r_pc + 32'd4;
  end

  assign w_deliver = !w_stall && !w_hold && !w_redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_miss_addr <= '0;
      r_buf_valid <= 1'b0;
      r_tag       <= '0;
      r_line      <= '0;
      r_idx       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_start_miss)
        r_miss_addr <= {r_pc[31:4], 4'h0};
      if (w_fill) begin
        r_line      <= mem_data;
        r_tag       <= r_miss_addr[31:4];
        r_buf_valid <= 1'b1;
      end
      if (w_deliver)
        r_idx <= r_idx + 4'd1;
    end
  end

  assign mem_req              = reset && (r_state == S_MISS);
  assign mem_addr             = !reset ? '0 :
                                (r_state == S_MISS) ? r_miss_addr : {r_pc[31:4], 4'h0};
  assign out_instruction      = reset ? w_insn : '0;
  assign out_PC               = reset ? r_pc : '0;
  assign out_complete_idx     = reset ? r_idx : '0;
  assign out_exception_vector = (reset && r_state == S_IDLE) ? w_vec : '0;
  assign out_i_cache_stall    = reset && w_stall;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table plus randomized traffic against
// a line-buffer reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_1000;
  localparam logic [31:0] MEM_LIMIT = 32'h0001_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic         clk;
  logic         reset;
  logic         hz, dstall, br, exc, mem_ready;
  logic [31:0]  bt, et;
  logic [127:0] mem_data;
  logic         mem_req;
  logic [31:0]  mem_addr, out_instruction, out_PC;
  logic [3:0]   out_complete_idx;
  logic [2:0]   out_exception_vector;
  logic         out_i_cache_stall;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .MEM_LIMIT(MEM_LIMIT),
    .NOP_INSN (NOP)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_IFID_write_disable(hz),
    .in_d_cache_stall     (dstall),
    .in_branch_taken      (br),
    .in_branch_target     (bt),
    .in_exception_redirect(exc),
    .in_exception_target  (et),
    .mem_req              (mem_req),
    .mem_addr             (mem_addr),
    .mem_ready            (mem_ready),
    .mem_data             (mem_data),
    .out_instruction      (out_instruction),
    .out_PC               (out_PC),
    .out_complete_idx     (out_complete_idx),
    .out_exception_vector (out_exception_vector),
    .out_i_cache_stall    (out_i_cache_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: the PC, a one-line cache image and an outstanding fill.
  logic [31:0] m_pc;
  bit          m_valid;
  logic [27:0] m_tag;
  logic [31:0] m_words [4];
  bit          m_wait;
  logic [31:0] m_line;
  logic [3:0]  m_idx;

  bit          x_stall, x_req;
  logic [31:0] x_addr, x_pc, x_insn;
  logic [3:0]  x_idx;
  logic [2:0]  x_vec;

  task automatic model_expect();
    logic [2:0] v;
    x_stall = 0; x_req = 0; x_addr = '0; x_pc = '0; x_insn = '0; x_idx = '0; x_vec = '0;
    if (!reset) return;
    x_pc  = m_pc;
    x_idx = m_idx;
    v = {1'b0, m_pc >= MEM_LIMIT, m_pc[1:0] != 2'b00};
    if (m_wait) begin
      x_stall = 1; x_req = 1; x_addr = m_line;
    end else if (v != 3'b000) begin
      x_insn = NOP; x_vec = v;
    end else if (m_valid && m_tag == m_pc[31:4]) begin
      x_insn = m_words[m_pc[3:2]];
    end else begin
      x_stall = 1;
    end
  endtask

  task automatic model_tick();
    bit stall_now, hold, redir;
    if (!reset) begin
      m_pc = RESET_PC; m_valid = 0; m_wait = 0; m_idx = '0; m_tag = '0;
      return;
    end
    model_expect();
    stall_now = x_stall;
    hold  = hz | dstall;
    redir = exc | br;
    if (m_wait) begin
      if (mem_ready) begin
        m_valid = 1;
        m_tag   = m_line[31:4];
        for (int k = 0; k < 4; k++) m_words[k] = mem_data[32*k +: 32];
        m_wait  = 0;
      end
    end else if (stall_now) begin
      m_wait = 1;
      m_line = {m_pc[31:4], 4'h0};
    end
    if (!stall_now && !hold && !redir) m_idx = m_idx + 4'd1;
    if (exc)                          m_pc = et;
    else if (br)                      m_pc = bt;
    else if (!hold && !stall_now)     m_pc = m_pc + 32'd4;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle();
    #1;
    model_expect();
    chk("mdl_stall", {31'd0, out_i_cache_stall}, {31'd0, x_stall});
    chk("mdl_req",   {31'd0, mem_req},           {31'd0, x_req});
    if (x_req || !reset) chk("mdl_addr", mem_addr, x_addr);
    chk("mdl_pc",    out_PC,                     x_pc);
    chk("mdl_insn",  out_instruction,            x_insn);
    chk("mdl_idx",   {28'd0, out_complete_idx},  {28'd0, x_idx});
    chk("mdl_vec",   {29'd0, out_exception_vector}, {29'd0, x_vec});
    @(posedge clk);
    model_tick();
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    bit           rst, ds, hz, br, ex, rdy;
    logic [31:0]  bt, et;
    logic [127:0] data;
    bit           e_stall, e_req;
    logic [31:0]  e_addr, e_pc, e_insn;
    logic [3:0]   e_idx;
    logic [2:0]   e_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit ds, bit hzv, bit brv, logic [31:0] btv, bit exv,
                              logic [31:0] etv, bit rdy, logic [127:0] d, bit es, bit er,
                              logic [31:0] ea, logic [31:0] ep, logic [31:0] ei,
                              logic [3:0] eidx, logic [2:0] ev);
    vec_t v;
    v.rst = rst; v.ds = ds; v.hz = hzv; v.br = brv; v.bt = btv; v.ex = exv; v.et = etv;
    v.rdy = rdy; v.data = d; v.e_stall = es; v.e_req = er; v.e_addr = ea; v.e_pc = ep;
    v.e_insn = ei; v.e_idx = eidx; v.e_vec = ev;
    tbl.push_back(v);
  endfunction

  function automatic logic [127:0] mkline(logic [31:0] p);
    return {p + 32'd3, p + 32'd2, p + 32'd1, p};
  endfunction

  function automatic logic [31:0] pick_target();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6)      return 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
    else if (r == 7) return 32'h0000_1000 + 32'($urandom_range(0, 255));
    else if (r == 8) return 32'h0000_FFE0 + (32'($urandom_range(0, 15)) << 2);
    else             return 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
  endfunction

  logic [127:0] LA, LB, LC, LD, LE, LF;

  initial begin
    reset = 0; hz = 0; dstall = 0; br = 0; exc = 0; mem_ready = 0;
    bt = '0; et = '0; mem_data = '0;
    LA = mkline(32'hA000_0000); LB = mkline(32'hB000_0000); LC = mkline(32'hC000_0000);
    LD = mkline(32'hD000_0000); LE = mkline(32'hE000_0000); LF = mkline(32'hF000_0000);

    //  rst ds hz br bt  ex et  rdy data  stall req addr  pc  insn  idx vec
    add(0,0,0,0,0,0,0,0,0,             0,0,0,            0,            0,            0,3'b000);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,            32'h1000,     0,            0,3'b000);
    add(1,0,0,0,0,0,0,1,LA,            1,1,32'h1000,     32'h1000,     0,            0,3'b000);
    for (int unsigned k = 0; k < 4; k++)
      add(1,0,0,0,0,0,0,0,0,           0,0,0,            32'h1000+4*k, 32'hA000_0000+k, 4'(k),3'b000);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,            32'h1010,     0,            4,3'b000);
    for (int unsigned k = 0; k < 5; k++)
      add(1,0,0,0,0,0,0,0,0,           1,1,32'h1010,     32'h1010,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,1,LB,            1,1,32'h1010,     32'h1010,     0,            4,3'b000);
    add(1,0,0,1,32'h2000,0,0,0,0,      0,0,0,            32'h1010,     32'hB000_0000,4,3'b000);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,            32'h2000,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,0,0,             1,1,32'h2000,     32'h2000,     0,            4,3'b000);
    add(1,0,0,1,32'h1004,0,0,0,0,      1,1,32'h2000,     32'h2000,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,1,LC,            1,1,32'h2000,     32'h1004,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,            32'h1004,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,1,LA,            1,1,32'h1000,     32'h1004,     0,            4,3'b000);
    add(1,0,0,1,32'h1008,1,32'h3000,0,0, 0,0,0,          32'h1004,     32'hA000_0001,4,3'b000);
    add(1,0,0,0,0,1,32'h1002,0,0,      1,0,0,            32'h3000,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,1,LD,            1,1,32'h3000,     32'h1002,     0,            4,3'b000);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,            32'h1002,     NOP,          4,3'b001);
    add(1,0,0,0,0,1,32'hFFFC,0,0,      0,0,0,            32'h1006,     NOP,          5,3'b001);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,            32'hFFFC,     0,            5,3'b000);
    add(1,0,0,0,0,0,0,1,LE,            1,1,32'hFFF0,     32'hFFFC,     0,            5,3'b000);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,            32'hFFFC,     32'hE000_0003,5,3'b000);
    for (int unsigned k = 0; k < 3; k++)
      add(1,1,0,0,0,0,0,0,0,           0,0,0,            32'h10000,    NOP,          6,3'b010);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,            32'h10000,    NOP,          6,3'b010);
    add(1,0,1,0,0,0,0,0,0,             0,0,0,            32'h10004,    NOP,          7,3'b010);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,            32'h10004,    NOP,          7,3'b010);
    add(1,0,0,0,0,1,32'h10001,0,0,     0,0,0,            32'h10008,    NOP,          8,3'b010);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,            32'h10001,    NOP,          8,3'b011);
    add(1,0,0,0,0,1,32'h1100,0,0,      0,0,0,            32'h10005,    NOP,          9,3'b011);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,            32'h1100,     0,            9,3'b000);
    add(1,0,0,0,0,0,0,0,0,             1,1,32'h1100,     32'h1100,     0,            9,3'b000);
    add(0,0,0,0,0,0,0,0,0,             0,0,0,            0,            0,            0,3'b000);
    add(1,0,0,0,0,0,0,1,LF,            1,0,0,            32'h1000,     0,            0,3'b000);
    add(1,0,0,0,0,0,0,1,LA,            1,1,32'h1000,     32'h1000,     0,            0,3'b000);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,            32'h1000,     32'hA000_0000,0,3'b000);

    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst; dstall = tbl[i].ds; hz = tbl[i].hz; br = tbl[i].br; bt = tbl[i].bt;
      exc = tbl[i].ex; et = tbl[i].et; mem_ready = tbl[i].rdy; mem_data = tbl[i].data;
      #1;
      chk("tbl_stall", {31'd0, out_i_cache_stall}, {31'd0, tbl[i].e_stall});
      chk("tbl_req",   {31'd0, mem_req},           {31'd0, tbl[i].e_req});
      if (tbl[i].e_req || !tbl[i].rst) chk("tbl_addr", mem_addr, tbl[i].e_addr);
      chk("tbl_pc",    out_PC,                     tbl[i].e_pc);
      chk("tbl_insn",  out_instruction,            tbl[i].e_insn);
      chk("tbl_idx",   {28'd0, out_complete_idx},  {28'd0, tbl[i].e_idx});
      chk("tbl_vec",   {29'd0, out_exception_vector}, {29'd0, tbl[i].e_vec});
      cycle();
    end

    for (int unsigned n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 127) != 0);
      dstall    = ($urandom_range(0, 7) == 0);
      hz        = ($urandom_range(0, 9) == 0);
      br        = ($urandom_range(0, 7) == 0);
      exc       = ($urandom_range(0, 15) == 0);
      bt        = pick_target();
      et        = pick_target();
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_data  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
